adjust_ctrl: RTL and testbench
==============================

# adjust_ctrl

Time-adjust controller for the DE2 digital clock. It debounces the three adjust push-buttons and runs the RUN/ADJUST mode state machine. It drives the `adjust`/`select` inputs of the display block and issues one-cycle increment commands (field + decimal step) to the time-register block. It also freezes timekeeping while adjusting and returns to RUN after an idle timeout.

## Interface
Parameters:
- DEBOUNCE_CYCLES, 1_000_000: consecutive stable cycles before a key level is accepted (20 ms @ 50 MHz).
- IDLE_TIMEOUT_CYCLES, 1_500_000_000: cycles in ADJUST with no key event before forced return to RUN (30 s).
- REPEAT_DELAY, 25_000_000: cycles the inc key is held before auto-repeat starts (0.5 s).
- REPEAT_PERIOD, 5_000_000: cycles between auto-repeat strobes (0.1 s).

Ports:
- CLOCK_50  in  1  sole clock, 50 MHz.
- reset  in  1  synchronous, active-high reset.
- key_mode_n  in  1  raw mode button, active-low, asynchronous.
- key_next_n  in  1  raw next-digit button, active-low, asynchronous.
- key_inc_n  in  1  raw increment button, active-low, asynchronous.
- adjust  out  1  1 = RUN display, 0 = ADJUST; feeds the display block's `adjust` input.
- select  out  4  digit under adjustment, 0..15; feeds the display block's `select` input.
- run_en  out  1  time-counter enable; 1 in RUN, 0 in ADJUST.
- inc_stb  out  1  one-cycle increment command.
- inc_field  out  3  0 ms, 1 s, 2 min, 3 hour, 4 day, 5 month, 6 year; valid with inc_stb.
- inc_step  out  2  0 ×1, 1 ×10, 2 ×100, 3 ×1000; valid with inc_stb.

## Operation
- Each key passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer holds a stable level, reset value released (1).
  - A counter runs while the synchronized level differs from the stable level. It clears whenever they match.
  - After DEBOUNCE_CYCLES consecutive differing cycles, the stable level takes the new value.
  - A 1→0 transition of the stable level yields a one-cycle press pulse.
- States:
  - RUN: adjust=1, run_en=1, select=0, inc_stb=0.
    - mode press → ADJUST; select loads 0, idle counter clears.
    - next and inc presses are ignored.
  - ADJUST: adjust=0, run_en=0.
    - mode press → RUN.
    - next press → select = select+1, wrapping 15→0.
    - inc press → inc_stb=1 with the field/step decoded from the current select.
    - Any press clears the idle counter. Otherwise it increments.
    - When the idle counter reaches IDLE_TIMEOUT_CYCLES → RUN.
- Priority for same-cycle presses: mode > next > inc. Lower-priority presses in that cycle are discarded, not queued.
- select → (field, step) decode:
  - 0/1 → ms ×1/×10.
  - 2/3 → s ×1/×10.
  - 4/5 → min ×1/×10.
  - 6/7 → hour ×1/×10.
  - 8/9 → day ×1/×10.
  - 10/11 → month ×1/×10.
  - 12/13/14/15 → year ×1/×10/×100/×1000.
- Range wrap of the incremented field is owned by the time-register block. This block only issues commands.
- Reset values:
  - Outputs: adjust=1, run_en=1, select=0, inc_stb=0, inc_field=0, inc_step=0.
  - Internals: state RUN, all counters 0, stable levels 1.
- Reset mid-ADJUST returns to RUN on the next edge. Any in-progress debounce or repeat is abandoned.

## Timing
- Press latency: the key edge is visible at the sync output 2 cycles later, and the stable level updates DEBOUNCE_CYCLES cycles after that. The press pulse and state/select/inc_stb updates occur on the following edge. All outputs are registered.
- Glitches shorter than DEBOUNCE_CYCLES never change the stable level.
- inc_stb is high for exactly one cycle per command. inc_field/inc_step are registered in the same cycle and held until the next command.
- Timeout: RUN is entered on the edge where the idle counter equals IDLE_TIMEOUT_CYCLES. A press in that same cycle wins: the state stays ADJUST and the counter clears.
- Counter widths hold their parameter values without overflow: 31 bits for the idle counter, 25 bits for the repeat counter, 20 bits for the debounce counter.

## Configuration
- ADJUST_AUTO_REPEAT_EN defined:
  - In ADJUST, while the inc stable level stays 0, a repeat counter starts at the press.
  - An additional inc_stb fires after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - Each repeat clears the idle counter.
  - Release, a mode or next press, or leaving ADJUST stops repeating and clears the counter.
- Undefined: exactly one inc_stb per press. The repeat counter is not synthesized.

## Test plan
Run with DEBOUNCE_CYCLES=4, IDLE_TIMEOUT_CYCLES=100, REPEAT_DELAY=20, REPEAT_PERIOD=5.
- Reset, no keys → adjust=1, run_en=1, select=0, inc_stb never asserted.
- key_mode_n low 3 cycles, then high → no state change. Held low 10 cycles → adjust=0, run_en=0, select=0 exactly 7 cycles after the falling edge.
- In ADJUST, 13 next presses, then one inc press → select=13; a single inc_stb with inc_field=6, inc_step=1. A further 3 next presses → select=0 (wrap).
- mode and next pressed in the same cycle while in ADJUST → RUN entered; select=0, no select increment.
- In ADJUST, no keys for 100 cycles → adjust=1 on the 100th-count edge. Repeat with an inc press at cycle 60 → timeout occurs 100 cycles after that press.
- ADJUST_AUTO_REPEAT_EN, select=4, inc held 40 cycles after the press pulse → inc_stb at press, +20, +25, +30, +35, +40 (6 strobes), all with inc_field=2, inc_step=0. Macro undefined → 1 strobe.

Source files
------------

// File: rtl/adjust_ctrl.sv
// Time-adjust controller: key synchronizers/debouncers and the RUN/ADJUST mode FSM.
// Optional build macro ADJUST_AUTO_REPEAT_EN adds held-key auto-repeat of increment commands.
module adjust_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1_000_000,
  parameter int unsigned IDLE_TIMEOUT_CYCLES = 1_500_000_000,
  parameter int unsigned REPEAT_DELAY        = 25_000_000,
  parameter int unsigned REPEAT_PERIOD       = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       key_mode_n,
  input  logic       key_next_n,
  input  logic       key_inc_n,
  output logic       adjust,
  output logic [3:0] select,
  output logic       run_en,
  output logic       inc_stb,
  output logic [2:0] inc_field,
  output logic [1:0] inc_step
);

  // state  | meaning
  // ST_RUN | clock running, keys other than mode ignored
  // ST_ADJ | timekeeping frozen, next/inc edit the selected digit

  localparam int DB_W   = 20;
  localparam int IDLE_W = 31;

  localparam logic [DB_W-1:0]   DB_LAST    = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE     = DB_W'(1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT_CYCLES);
  localparam logic [IDLE_W-1:0] IDLE_ONE   = IDLE_W'(1);

  if (DEBOUNCE_CYCLES == 0 || REPEAT_PERIOD == 0 || REPEAT_PERIOD > REPEAT_DELAY) begin : g_cfg_err
    $error("adjust_ctrl: invalid timing parameters");
  end

  typedef enum logic {ST_RUN = 1'b0, ST_ADJ = 1'b1} state_e;

  logic [2:0]           raw_n;
  logic [2:0]           sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2:0]           stable_q, stable_d, prev_q, prev_d;
  logic [2:0][DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [2:0]           press;
  logic                 press_mode, press_next, press_inc;

  state_e               state_q, state_d;
  logic [3:0]           select_q, select_d;
  logic [IDLE_W-1:0]    idle_q, idle_d;
  logic                 adjust_q, adjust_d, run_en_q, run_en_d;
  logic                 inc_stb_q, inc_stb_d;
  logic [2:0]           inc_field_q, inc_field_d;
  logic [1:0]           inc_step_q, inc_step_d;
  logic                 fire_inc;
  logic                 rep_fire;

  assign raw_n = {key_inc_n, key_next_n, key_mode_n};

  always_comb begin
    sync1_d  = raw_n;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    prev_d   = stable_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) stable_d[i] = sync2_q[i];
        else                        db_cnt_d[i] = db_cnt_q[i] + DB_ONE;
      end
    end
  end

  assign press      = prev_q & ~stable_q;
  assign press_mode = press[0];
  assign press_next = press[1];
  assign press_inc  = press[2];

  always_comb begin
    state_d     = state_q;
    select_d    = select_q;
    idle_d      = '0;
    inc_stb_d   = 1'b0;
    inc_field_d = inc_field_q;
    inc_step_d  = inc_step_q;
    fire_inc    = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (press_mode) begin
          state_d  = ST_ADJ;
          select_d = '0;
        end
      end
      default: begin
        // The edge on which the count would reach the limit is the one that returns to RUN.
        idle_d = idle_q + IDLE_ONE;
        if (press_mode) begin
          state_d  = ST_RUN;
          select_d = '0;
          idle_d   = '0;
        end else if (press_next) begin
          select_d = select_q + 4'd1;
          idle_d   = '0;
        end else if (press_inc || rep_fire) begin
          fire_inc = 1'b1;
          idle_d   = '0;
        end else if (idle_d == IDLE_LIMIT) begin
          state_d  = ST_RUN;
          select_d = '0;
          idle_d   = '0;
        end
      end
    endcase
    if (fire_inc) begin
      inc_stb_d = 1'b1;
      if (select_q < 4'd12) begin
        inc_field_d = select_q[3:1];
        inc_step_d  = {1'b0, select_q[0]};
      end else begin
        inc_field_d = 3'd6;
        inc_step_d  = select_q[1:0];
      end
    end
    adjust_d = (state_d == ST_RUN);
    run_en_d = (state_d == ST_RUN);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q     <= '1;
      sync2_q     <= '1;
      stable_q    <= '1;
      prev_q      <= '1;
      db_cnt_q    <= '0;
      state_q     <= ST_RUN;
      select_q    <= '0;
      idle_q      <= '0;
      adjust_q    <= 1'b1;
      run_en_q    <= 1'b1;
      inc_stb_q   <= 1'b0;
      inc_field_q <= '0;
      inc_step_q  <= '0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      stable_q    <= stable_d;
      prev_q      <= prev_d;
      db_cnt_q    <= db_cnt_d;
      state_q     <= state_d;
      select_q    <= select_d;
      idle_q      <= idle_d;
      adjust_q    <= adjust_d;
      run_en_q    <= run_en_d;
      inc_stb_q   <= inc_stb_d;
      inc_field_q <= inc_field_d;
      inc_step_q  <= inc_step_d;
    end
  end

`ifdef ADJUST_AUTO_REPEAT_EN
  localparam int REP_W = 25;
  localparam logic [REP_W-1:0] REP_LAST   = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_RELOAD = REP_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam logic [REP_W-1:0] REP_ONE    = REP_W'(1);

  logic             rep_act_q, rep_act_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

  assign rep_fire = rep_act_q && !stable_q[2] && (rep_cnt_q == REP_LAST);

  always_comb begin
    rep_act_d = rep_act_q;
    rep_cnt_d = rep_cnt_q;
    if (state_d != ST_ADJ || stable_q[2] || press_mode || press_next) begin
      rep_act_d = 1'b0;
      rep_cnt_d = '0;
    end else if (press_inc) begin
      rep_act_d = 1'b1;
      rep_cnt_d = '0;
    end else if (rep_act_q) begin
      // After the first repeat, reload so later strobes come one period apart.
      rep_cnt_d = (rep_cnt_q == REP_LAST) ? REP_RELOAD : rep_cnt_q + REP_ONE;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      rep_act_q <= 1'b0;
      rep_cnt_q <= '0;
    end else begin
      rep_act_q <= rep_act_d;
      rep_cnt_q <= rep_cnt_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign adjust    = adjust_q;
  assign run_en    = run_en_q;
  assign select    = select_q;
  assign inc_stb   = inc_stb_q;
  assign inc_field = inc_field_q;
  assign inc_step  = inc_step_q;

endmodule

// File: tb/tb_adjust_ctrl.sv
// Self-checking bench for adjust_ctrl: vector table, directed timing sequences and
// randomized key activity compared cycle by cycle against a behavioural model.
module tb_adjust_ctrl;

  localparam int DB   = 4;
  localparam int IDLE = 100;
  localparam int RD   = 20;
  localparam int RP   = 5;

  logic       clk;
  logic       reset;
  logic       key_mode_n, key_next_n, key_inc_n;
  logic       adjust, run_en, inc_stb;
  logic [3:0] select;
  logic [2:0] inc_field;
  logic [1:0] inc_step;

  adjust_ctrl #(
    .DEBOUNCE_CYCLES(DB), .IDLE_TIMEOUT_CYCLES(IDLE),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .CLOCK_50(clk), .reset(reset),
    .key_mode_n(key_mode_n), .key_next_n(key_next_n), .key_inc_n(key_inc_n),
    .adjust(adjust), .select(select), .run_en(run_en),
    .inc_stb(inc_stb), .inc_field(inc_field), .inc_step(inc_step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int tcnt  = 0;
  int stb_seen = 0;

  // Behavioural model state
  bit m_hist[3][$];
  bit m_stable[3];
  bit m_pend[3];
  bit m_adj;
  int m_sel, m_idle, m_age;
  bit m_rep;
  bit m_stb;
  int m_fld, m_stp;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, tcnt);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_hist[k].delete();
      for (int j = 0; j < DB + 2; j++) m_hist[k].push_back(1'b1);
      m_stable[k] = 1'b1;
      m_pend[k]   = 1'b0;
    end
    m_adj = 0; m_sel = 0; m_idle = 0; m_age = 0; m_rep = 0;
    m_stb = 0; m_fld = 0; m_stp = 0;
  endtask

  task automatic model_step(input bit rst, input bit [2:0] raw);
    bit pm, pn, pi, fire, rfire, all_diff;
    int n;
    if (rst) begin
      model_reset();
      return;
    end
    pm = m_pend[0]; pn = m_pend[1]; pi = m_pend[2];
    m_stb = 0; fire = 0; rfire = 0;
    if (!m_adj) begin
      if (pm) begin m_adj = 1; m_sel = 0; m_idle = 0; end
    end else begin
`ifdef ADJUST_AUTO_REPEAT_EN
      if (m_rep && !m_stable[2]) begin
        m_age++;
        rfire = (m_age >= RD) && ((m_age - RD) % RP == 0);
      end
`endif
      if (pm) begin
        m_adj = 0; m_sel = 0;
      end else if (pn) begin
        m_sel = (m_sel + 1) % 16; m_idle = 0;
      end else if (pi) begin
        fire = 1; m_idle = 0;
`ifdef ADJUST_AUTO_REPEAT_EN
        m_rep = 1; m_age = 0;
`endif
      end else if (rfire) begin
        fire = 1; m_idle = 0;
      end else begin
        m_idle++;
        if (m_idle == IDLE) begin m_adj = 0; m_sel = 0; end
      end
      if (pm || pn || m_stable[2]) m_rep = 0;
    end
    if (!m_adj) m_rep = 0;
    if (fire) begin
      m_stb = 1;
      m_fld = (m_sel < 12) ? m_sel / 2 : 6;
      m_stp = (m_sel < 12) ? m_sel % 2 : m_sel - 12;
    end
    // Stable level flips once the last DB synchronized samples (raw delayed by 2) all disagree.
    for (int k = 0; k < 3; k++) begin
      m_hist[k].push_back(raw[k]);
      n = m_hist[k].size();
      all_diff = 1;
      for (int j = 0; j < DB; j++) if (m_hist[k][n - 3 - j] == m_stable[k]) all_diff = 0;
      m_pend[k] = 0;
      if (all_diff) begin
        m_pend[k]   = m_stable[k];
        m_stable[k] = !m_stable[k];
      end
      while (m_hist[k].size() > DB + 4) void'(m_hist[k].pop_front());
    end
  endtask

  function automatic int exp_vec();
    logic [11:0] v;
    v = {!m_adj, !m_adj, 4'(m_sel), m_stb, 3'(m_fld), 2'(m_stp)};
    return int'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(reset, {key_inc_n, key_next_n, key_mode_n});
    @(negedge clk);
    tcnt++;
    if (inc_stb) stb_seen++;
    check("cycle_outputs", int'({adjust, run_en, select, inc_stb, inc_field, inc_step}), exp_vec());
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: key_mode_n = v;
      1: key_next_n = v;
      default: key_inc_n = v;
    endcase
  endtask

  task automatic press(input int k);
    set_key(k, 1'b0);
    hold(6);
    set_key(k, 1'b1);
    hold(8);
  endtask

  // Waits until adjust reaches the wanted level; returns the tick it was seen on.
  task automatic wait_adjust(input logic lvl, input int budget, input string name, output int t);
    int i;
    t = -1;
    for (i = 0; i < budget && adjust !== lvl; i++) tick();
    if (adjust !== lvl) check(name, int'(adjust), int'(lvl));
    else t = tcnt;
  endtask

  task automatic wait_stb(input int budget, output int t);
    int i;
    t = -1;
    for (i = 0; i < budget && inc_stb !== 1'b1; i++) tick();
    if (inc_stb !== 1'b1) check("wait_inc_stb", int'(inc_stb), 1);
    else t = tcnt;
  endtask

  typedef struct {
    int nexts;
    bit do_inc;
    int exp_sel;
    int exp_stb;
    int exp_fld;
    int exp_stp;
  } vec_t;

  vec_t vtab[10];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", tcnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, tp, lat, s0;
    int offs[$];
    int exp_offs[$];
    bit [2:0] lvl;
    int rem[3];

    vtab[0] = '{0,  1, 0,  1, 0, 0};
    vtab[1] = '{3,  1, 3,  1, 1, 1};
    vtab[2] = '{5,  1, 8,  1, 4, 0};
    vtab[3] = '{3,  1, 11, 1, 5, 1};
    vtab[4] = '{1,  1, 12, 1, 6, 0};
    vtab[5] = '{2,  1, 14, 1, 6, 2};
    vtab[6] = '{1,  1, 15, 1, 6, 3};
    vtab[7] = '{1,  0, 0,  0, 6, 3};
    vtab[8] = '{13, 1, 13, 1, 6, 1};
    vtab[9] = '{3,  0, 0,  0, 6, 1};

    model_reset();
    reset = 1'b1; key_mode_n = 1'b1; key_next_n = 1'b1; key_inc_n = 1'b1;
    @(negedge clk);
    hold(3);
    reset = 1'b0;
    check("reset_adjust", int'(adjust), 1);
    check("reset_run_en", int'(run_en), 1);
    check("reset_select", int'(select), 0);
    check("reset_inc", int'({inc_stb, inc_field, inc_step}), 0);
    hold(20);
    check("idle_no_stb", stb_seen, 0);

    // Short glitch on mode must not be accepted.
    key_mode_n = 1'b0; hold(3); key_mode_n = 1'b1; hold(10);
    check("glitch_adjust", int'(adjust), 1);

    // Held mode key: ADJUST appears on the 7th edge after the fall.
    key_mode_n = 1'b0;
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (adjust == 1'b0 && lat == 0) lat = i;
    end
    check("mode_latency", lat, 7);
    check("adj_run_en", int'(run_en), 0);
    check("adj_select", int'(select), 0);
    key_mode_n = 1'b1; hold(8);

    for (int r = 0; r < 10; r++) begin
      s0 = stb_seen;
      for (int p = 0; p < vtab[r].nexts; p++) press(1);
      if (vtab[r].do_inc) press(2);
      check($sformatf("vec%0d_select", r), int'(select), vtab[r].exp_sel);
      check($sformatf("vec%0d_strobes", r), stb_seen - s0, vtab[r].exp_stb);
      check($sformatf("vec%0d_field", r), int'(inc_field), vtab[r].exp_fld);
      check($sformatf("vec%0d_step", r), int'(inc_step), vtab[r].exp_stp);
    end

    // Mode and next together: mode wins, next discarded.
    press(1); press(1);
    check("pre_combo_select", int'(select), 2);
    key_mode_n = 1'b0; key_next_n = 1'b0; hold(6);
    key_mode_n = 1'b1; key_next_n = 1'b1; hold(8);
    check("combo_adjust", int'(adjust), 1);
    check("combo_select", int'(select), 0);

    s0 = stb_seen;
    press(1); press(2);
    check("run_ignore_adjust", int'(adjust), 1);
    check("run_ignore_select", int'(select), 0);
    check("run_ignore_stb", stb_seen - s0, 0);

    // Idle timeout from entry.
    key_mode_n = 1'b0;
    wait_adjust(1'b0, 20, "enter_adjust_1", t0);
    key_mode_n = 1'b1;
    wait_adjust(1'b1, 200, "timeout_1", t1);
    check("timeout_cycles", t1 - t0, IDLE);

    // Idle timeout restarted by an inc press 60 cycles in.
    key_mode_n = 1'b0;
    wait_adjust(1'b0, 20, "enter_adjust_2", t0);
    key_mode_n = 1'b1;
    hold(53);
    key_inc_n = 1'b0;
    wait_stb(20, tp);
    key_inc_n = 1'b1;
    check("inc_at_60", tp - t0, 60);
    wait_adjust(1'b1, 200, "timeout_2", t1);
    check("timeout_after_inc", t1 - tp, IDLE);

    // Held inc key at select 4.
    hold(5);
    press(0);
    for (int p = 0; p < 4; p++) press(1);
    check("rep_select", int'(select), 4);
    key_inc_n = 1'b0;
    wait_stb(20, tp);
    offs.push_back(0);
    for (int i = 1; i <= 60; i++) begin
      if (i == 37) key_inc_n = 1'b1;
      tick();
      if (inc_stb) begin
        offs.push_back(tcnt - tp);
        check("rep_field", int'(inc_field), 2);
        check("rep_step", int'(inc_step), 0);
      end
    end
`ifdef ADJUST_AUTO_REPEAT_EN
    exp_offs = '{0, 20, 25, 30, 35, 40};
`else
    exp_offs = '{0};
`endif
    check("rep_count", offs.size(), exp_offs.size());
    for (int i = 0; i < exp_offs.size() && i < offs.size(); i++)
      check($sformatf("rep_offset%0d", i), offs[i], exp_offs[i]);
    press(0);
    check("rep_exit_adjust", int'(adjust), 1);

    // Reset in the middle of ADJUST.
    press(0); press(1);
    check("pre_reset_select", int'(select), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("midreset_adjust", int'(adjust), 1);
    check("midreset_select", int'(select), 0);
    check("midreset_run_en", int'(run_en), 1);

    // Randomized key activity against the model.
    lvl = 3'b111;
    rem[0] = 40; rem[1] = 3; rem[2] = 5;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = ~lvl[k];
          rem[k] = (k == 0 && lvl[k]) ? int'($urandom_range(30, 150)) : int'($urandom_range(1, 12));
        end
        rem[k]--;
      end
      key_mode_n = lvl[0]; key_next_n = lvl[1]; key_inc_n = lvl[2];
      reset = ($urandom_range(0, 799) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
